// File: rtl/pc_sequencer_if.sv
// Control/status bundle between decode/execute and the program-counter unit.
// The controller side drives the requests; the sequencer side drives the PC views.
interface pc_sequencer_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned IMM_BITS  = 16,
   parameter int unsigned JIDX_BITS = 26
);
   logic                 stall;
   logic                 branch_taken;
   logic                 jump;
   logic                 jump_reg;
   logic [IMM_BITS-1:0]  imm;
   logic [JIDX_BITS-1:0] jidx;
   logic [WIDTH-1:0]     rs_val;
   logic [WIDTH-1:0]     pc;
   logic [WIDTH-1:0]     pc_plus4;
   logic [WIDTH-1:0]     next_pc;
   logic                 redirect;
   logic                 in_delay_slot;
   logic                 misalign;

   modport master (
      output stall, branch_taken, jump, jump_reg, imm, jidx, rs_val,
      input  pc, pc_plus4, next_pc, redirect, in_delay_slot, misalign
   );

   modport slave (
      input  stall, branch_taken, jump, jump_reg, imm, jidx, rs_val,
      output pc, pc_plus4, next_pc, redirect, in_delay_slot, misalign
   );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with PC+4, branch/jump/jump-register target generation,
// fixed-priority transfer selection, stall hold and an optional branch delay slot.
module pc_sequencer #(
   parameter int unsigned     WIDTH        = 32,
   parameter int unsigned     IMM_BITS     = 16,
   parameter int unsigned     JIDX_BITS    = 26,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter bit              DELAY_SLOT   = 1'b0
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);

   typedef enum logic {StIdle, StDelay} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] target_q, target_d;
   logic             redirect_q, redirect_d;
   logic             ds_q, ds_d;

   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] imm_ext;
   logic [WIDTH-1:0] br_tgt;
   logic [WIDTH-1:0] j_tgt;
   logic [WIDTH-1:0] jr_tgt;
   logic [WIDTH-1:0] sel_tgt;
   logic [WIDTH-1:0] next_pc;
   logic             xfer;

   if (WIDTH < JIDX_BITS + 2) begin : g_bad_width
      $error("WIDTH must be at least JIDX_BITS+2");
   end
   if (IMM_BITS > WIDTH - 2) begin : g_bad_imm
      $error("IMM_BITS must not exceed WIDTH-2");
   end
   if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_rv
      $error("RESET_VECTOR must be word aligned");
   end

   assign pc_plus4 = pc_q + WIDTH'(4);
   assign imm_ext  = {{(WIDTH - IMM_BITS){bus.imm[IMM_BITS-1]}}, bus.imm};
   assign br_tgt   = pc_plus4 + (imm_ext << 2);
   assign jr_tgt   = {bus.rs_val[WIDTH-1:2], 2'b00};

   // Jump keeps the upper region bits of pc+4 unless the index fills the whole word.
   if (WIDTH == JIDX_BITS + 2) begin : g_jtgt_full
      assign j_tgt = {bus.jidx, 2'b00};
   end else begin : g_jtgt_region
      assign j_tgt = {pc_plus4[WIDTH-1:JIDX_BITS+2], bus.jidx, 2'b00};
   end

   // Fixed priority: jump_reg > jump > branch_taken > sequential.
   always_comb begin
      xfer    = 1'b1;
      sel_tgt = pc_plus4;
      if (bus.jump_reg) begin
         sel_tgt = jr_tgt;
      end else if (bus.jump) begin
         sel_tgt = j_tgt;
      end else if (bus.branch_taken) begin
         sel_tgt = br_tgt;
      end else begin
         xfer = 1'b0;
      end
   end

   // Next-state: immediate transfer, or defer through one delay-slot fetch.
   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      redirect_d = 1'b0;
      ds_d       = 1'b0;
      next_pc    = pc_plus4;
      if (!DELAY_SLOT) begin
         redirect_d = xfer;
         if (xfer) begin
            next_pc = sel_tgt;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (xfer) begin
                  target_d = sel_tgt;
                  ds_d     = 1'b1;
                  state_d  = StDelay;
               end
            end
            StDelay: begin
               // Requests arriving while the slot instruction is in flight are dropped.
               next_pc    = target_q;
               redirect_d = 1'b1;
               state_d    = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State register: reset wins over stall; stall freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VECTOR;
         state_q    <= StIdle;
         target_q   <= '0;
         redirect_q <= 1'b0;
         ds_q       <= 1'b0;
      end else if (!bus.stall) begin
         pc_q       <= next_pc;
         state_q    <= state_d;
         target_q   <= target_d;
         redirect_q <= redirect_d;
         ds_q       <= ds_d;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_plus4      = pc_plus4;
   assign bus.next_pc       = next_pc;
   assign bus.redirect      = redirect_q;
   assign bus.in_delay_slot = ds_q;
   assign bus.misalign      = bus.jump_reg & (bus.rs_val[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance without and one with a delay slot.
// Stimulus pushes the expected post-edge state; a monitor pops and compares each cycle.
module tb_pc_sequencer;

   typedef struct {
      int          tag;
      logic [31:0] pc;
      logic        red;
      logic        ds;
      logic        chk_mis;
      logic        mis;
   } exp_t;

   logic clk;
   logic rst0, rst1;
   int   checks;
   int   errors;
   int   tag;
   exp_t q0[$];
   exp_t q1[$];

   pc_sequencer_if #(.WIDTH(32), .IMM_BITS(16), .JIDX_BITS(26)) if0 ();
   pc_sequencer_if #(.WIDTH(32), .IMM_BITS(16), .JIDX_BITS(26)) if1 ();

   pc_sequencer #(
      .WIDTH(32), .IMM_BITS(16), .JIDX_BITS(26), .RESET_VECTOR(32'h0), .DELAY_SLOT(1'b0)
   ) dut0 (
      .clk(clk),
      .rst(rst0),
      .bus(if0)
   );

   pc_sequencer #(
      .WIDTH(32), .IMM_BITS(16), .JIDX_BITS(26), .RESET_VECTOR(32'h0), .DELAY_SLOT(1'b1)
   ) dut1 (
      .clk(clk),
      .rst(rst1),
      .bus(if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int t, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, t, got, exp);
      end
   endtask

   // Monitor: after every rising edge compare each instance against its queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0.pc", e.tag, if0.pc, e.pc);
            chk("d0.redirect", e.tag, 32'(if0.redirect), 32'(e.red));
            chk("d0.in_delay_slot", e.tag, 32'(if0.in_delay_slot), 32'(e.ds));
            if (e.chk_mis) chk("d0.misalign", e.tag, 32'(if0.misalign), 32'(e.mis));
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1.pc", e.tag, if1.pc, e.pc);
            chk("d1.redirect", e.tag, 32'(if1.redirect), 32'(e.red));
            chk("d1.in_delay_slot", e.tag, 32'(if1.in_delay_slot), 32'(e.ds));
            if (e.chk_mis) chk("d1.misalign", e.tag, 32'(if1.misalign), 32'(e.mis));
         end
      end
   end

   // Drive one cycle of inputs at the falling edge and queue the expected result.
   task automatic step(input bit d, input bit r, input bit s, input bit br, input bit j,
                       input bit jr, input logic [15:0] im, input logic [25:0] ji,
                       input logic [31:0] rs, input logic [31:0] epc, input bit ered,
                       input bit eds, input bit ecm, input bit emis);
      exp_t e;
      @(negedge clk);
      if (!d) begin
         rst0 = r; if0.stall = s; if0.branch_taken = br; if0.jump = j; if0.jump_reg = jr;
         if0.imm = im; if0.jidx = ji; if0.rs_val = rs;
      end else begin
         rst1 = r; if1.stall = s; if1.branch_taken = br; if1.jump = j; if1.jump_reg = jr;
         if1.imm = im; if1.jidx = ji; if1.rs_val = rs;
      end
      tag++;
      e.tag = tag; e.pc = epc; e.red = ered; e.ds = eds; e.chk_mis = ecm; e.mis = emis;
      if (!d) q0.push_back(e);
      else    q1.push_back(e);
   endtask

   initial begin
      checks = 0; errors = 0; tag = 0;
      rst0 = 1'b1; rst1 = 1'b1;
      if0.stall = 0; if0.branch_taken = 0; if0.jump = 0; if0.jump_reg = 0;
      if0.imm = '0; if0.jidx = '0; if0.rs_val = '0;
      if1.stall = 0; if1.branch_taken = 0; if1.jump = 0; if1.jump_reg = 0;
      if1.imm = '0; if1.jidx = '0; if1.rs_val = '0;

      // ---- no delay slot ----   d r s br j jr imm      jidx    rs            pc  red ds cm mis
      step(0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 0, 0, 0, 0);  // rst beats stall
      step(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h4, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h8, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'hC, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h100, 32'h100, 1, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0, 16'hFFFF, 26'h0, 32'h0, 32'h100, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 16'h0010, 26'h0, 32'h0, 32'h144, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 0, 0, 0, 0);       // wrap
      step(0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h3000_0000, 32'h3000_0000, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 16'h0, 26'h10, 32'h0, 32'h3000_0040, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 16'h0, 26'h10, 32'h1234_5677, 32'h1234_5674, 1, 0, 1, 1);
      step(0, 0, 0, 1, 1, 0, 16'h0010, 26'h10, 32'h0, 32'h1000_0040, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 16'h0004, 26'h0, 32'h0, 32'h1000_0040, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 16'h0004, 26'h0, 32'h0, 32'h1000_0040, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 16'h0004, 26'h0, 32'h0, 32'h1000_0040, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 16'h0004, 26'h0, 32'h0, 32'h1000_0054, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h1000_0058, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h0, 32'h0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 16'hFFF0, 26'h0, 32'h0, 32'hFFFF_FFC4, 1, 0, 0, 0); // backward wrap
      step(0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 0, 0, 0, 0);

      // ---- delay slot ----
      step(1, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h200, 32'h4, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h200, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 16'h0, 26'h80, 32'h0, 32'h204, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0, 16'h0010, 26'h0, 32'h0, 32'h200, 1, 0, 0, 0); // branch ignored
      step(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h204, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 16'h0, 26'h40, 32'h0, 32'h208, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h208, 0, 1, 0, 0);    // stalled in slot
      step(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h100, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 16'h0, 26'h80, 32'h0, 32'h104, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 0, 0, 0, 0);      // reset mid-slot
      step(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h4, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h8, 0, 0, 0, 0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
      if (q0.size() > 0 || q1.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q0.size() + q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the MIPS-style datapath.
- Folds the existing combinational pieces into one registered block: PC+4 adder, sign extend, shift-left-2, jump-address concatenation and next-PC mux.
- Adds behaviour those pieces lack: stall hold, priority-resolved control transfer, and an optional one-instruction branch delay slot driven by a small FSM.
- Feeds the instruction-memory address; decode/execute supply the control inputs.

Parameters:
- WIDTH, 32: PC and data width. Legal only if WIDTH >= JIDX_BITS+2.
- IMM_BITS, 16: branch immediate width. Legal only if IMM_BITS <= WIDTH-2.
- JIDX_BITS, 26: jump index width.
- RESET_VECTOR, 0: PC value after reset. Must be word aligned.
- DELAY_SLOT, 0: 0 = transfer takes effect immediately; 1 = one delay-slot instruction executes before the transfer.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all state this cycle
- branch_taken  in  1  conditional branch resolved taken
- jump  in  1  J-type jump
- jump_reg  in  1  jump to register
- imm  in  IMM_BITS  branch offset, in words, signed
- jidx  in  JIDX_BITS  jump index
- rs_val  in  WIDTH  register target for jump_reg
- pc  out  WIDTH  current PC (registered)
- pc_plus4  out  WIDTH  pc+4 (combinational)
- next_pc  out  WIDTH  value loaded at next non-stalled edge (combinational)
- redirect  out  1  registered; high while pc holds a non-sequential target
- in_delay_slot  out  1  registered; high while pc is a delay-slot instruction
- misalign  out  1  combinational; jump_reg & (rs_val[1:0] != 0)

Behaviour:
- **Reset** (rst=1 at an edge, overrides stall and all requests): pc=RESET_VECTOR, redirect=0, in_delay_slot=0, FSM=IDLE, target_q=0.
- **Arithmetic**, all modulo 2^WIDTH:
  - pc_plus4 = pc+4.
  - br_tgt = pc_plus4 + (sign_extend(imm) << 2).
  - j_tgt = {pc_plus4[WIDTH-1:JIDX_BITS+2], jidx, 2'b00}. When WIDTH == JIDX_BITS+2 there are no upper bits.
  - jr_tgt = {rs_val[WIDTH-1:2], 2'b00}.
- **Priority:** jump_reg > jump > branch_taken > sequential. Simultaneous requests select the highest-priority target only.
- **stall=1:** pc, FSM, target_q, redirect and in_delay_slot all hold. Requests presented during a stall are not latched; the requester must keep them asserted.
- **DELAY_SLOT=0:**
  - next_pc = selected target.
  - redirect <= (a transfer was selected).
  - in_delay_slot is constantly 0.
  - Latency: a transfer request at cycle N gives pc = target at cycle N+1.
- **DELAY_SLOT=1, FSM IDLE/DELAY:**
  - IDLE with a transfer selected: target_q <= target, pc <= pc_plus4, in_delay_slot <= 1, redirect <= 0, go to DELAY.
  - DELAY: requests are ignored; next_pc = target_q. Next non-stalled edge: pc <= target_q, redirect <= 1, in_delay_slot <= 0, go to IDLE.
  - IDLE with no transfer: pc <= pc_plus4, redirect <= 0.
  - Request at cycle N gives pc = delay-slot address at N+1 and pc = target at N+2, plus any stall cycles.
- **Boundaries:**
  - pc = 0xFFFF_FFFC sequential gives 0 (wrap; no flag).
  - Backward branches below 0 wrap.
  - rst during DELAY abandons target_q.
  - misalign is informational only; the transfer still proceeds with the low bits cleared.
- No combinational path from inputs to pc or redirect; next_pc, pc_plus4 and misalign are combinational.

Test Plan:
- **Reset and sequential flow:** rst=1 then release, no requests, 4 cycles → pc = 0x0, 0x4, 0x8, 0xC; redirect=0 throughout; rst asserted together with stall=1 still gives pc=0.
- **Branch and wrap:**
  - pc=0x100, branch_taken=1, imm=16'hFFFF → next cycle pc=0x100, redirect=1.
  - imm=16'h0010 → pc=0x144.
  - From pc=0xFFFF_FFFC with no request → pc=0x0.
- **Jump and priority:**
  - pc=0x3000_0000, jump=1, jidx=26'h10 → pc=0x3000_0040.
  - Same cycle with jump_reg=1, rs_val=0x1234_5677 → pc=0x1234_5674, misalign=1.
  - jump together with branch_taken → jump target wins.
- **Stall:** stall=1 for 3 cycles with branch_taken=1 → pc frozen. Release with branch still asserted → target loaded the next cycle.
- **Delay slot (DELAY_SLOT=1):**
  - pc=0x200, jump=1, jidx=26'h80 → pc=0x204 with in_delay_slot=1, then pc=0x200 with redirect=1.
  - A branch requested during DELAY is ignored.
- **Reset mid-DELAY (DELAY_SLOT=1):** rst while in_delay_slot=1 → pc=RESET_VECTOR, in_delay_slot=0, and sequential fetch continues from RESET_VECTOR (no stale jump).
